// File: rtl/timer_apb_arbiter.sv
//-----------------------------------------------------------------------------
// timer_apb_arbiter
//
// Purpose:
//   2:1 APB arbiter sharing the timer APB slave port between a CPU requester
//   (m0) and a debug/DMA requester (m1). Each transfer is granted either
//   round-robin or with fixed priority to m0. A clean SETUP/ACCESS sequence
//   is regenerated downstream from registered command fields. The response
//   goes only to the granted requester.
//
// Ports:
//   sys_clk, sys_rst_n         clock (rising edge), async active-low reset
//   mN_psel/penable/pwrite     requester N control (N = 0,1); penable ignored
//   mN_paddr/pwdata/pstrb      requester N command fields
//   mN_prdata/pready/pslverr   requester N response (zero when not granted)
//   tim_psel/penable           downstream phase control
//   tim_pwrite/paddr/pwdata    registered command of the granted transfer
//   tim_pstrb                  registered strobes, forced to zero on reads
//   tim_prdata/pready/pslverr  downstream slave response
//
// Configuration:
//   TIMER_ARB_TIMEOUT_EN  when defined, an ACCESS phase that lasts
//                         TIMEOUT_CYC cycles without tim_pready is
//                         terminated with an error response.
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module timer_apb_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int DATA_W      = 32,
    parameter int FIXED_PRIO  = 0,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,

    input  logic                  m0_psel,
    input  logic                  m0_penable,
    input  logic                  m0_pwrite,
    input  logic [ADDR_W-1:0]     m0_paddr,
    input  logic [DATA_W-1:0]     m0_pwdata,
    input  logic [DATA_W/8-1:0]   m0_pstrb,
    output logic [DATA_W-1:0]     m0_prdata,
    output logic                  m0_pready,
    output logic                  m0_pslverr,

    input  logic                  m1_psel,
    input  logic                  m1_penable,
    input  logic                  m1_pwrite,
    input  logic [ADDR_W-1:0]     m1_paddr,
    input  logic [DATA_W-1:0]     m1_pwdata,
    input  logic [DATA_W/8-1:0]   m1_pstrb,
    output logic [DATA_W-1:0]     m1_prdata,
    output logic                  m1_pready,
    output logic                  m1_pslverr,

    output logic                  tim_psel,
    output logic                  tim_penable,
    output logic                  tim_pwrite,
    output logic [ADDR_W-1:0]     tim_paddr,
    output logic [DATA_W-1:0]     tim_pwdata,
    output logic [DATA_W/8-1:0]   tim_pstrb,
    input  logic [DATA_W-1:0]     tim_prdata,
    input  logic                  tim_pready,
    input  logic                  tim_pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic grant;
    logic last_grant;
    logic any_req;
    logic pick;
    logic complete;
    logic timed_out;
    logic [DATA_W-1:0] rsp_data;
    logic rsp_err;

    // Requester enables play no part in arbitration.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    assign any_req = m0_psel | m1_psel;

    // On a tie, round-robin hands the grant to whoever was not served last.
    always_comb begin
        pick = 1'b0;
        if (m0_psel && m1_psel) begin
            pick = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (m1_psel) begin
            pick = 1'b1;
        end
    end

`ifdef TIMER_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // A ready in the timeout cycle wins, so the timeout needs tim_pready low.
    assign timed_out = (state == ACCESS) && !tim_pready &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !tim_pready && !timed_out) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYC;

    assign timed_out = 1'b0;
`endif

    assign complete = (state == ACCESS) && (tim_pready || timed_out);

    // A forced termination returns zero data with an error flag.
    assign rsp_data = tim_pready ? tim_prdata : '0;
    assign rsp_err  = tim_pready ? tim_pslverr : 1'b1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response reaches a requester only while it still holds psel; a
    // requester that abandoned its granted transfer never sees the result.
    always_comb begin
        state_next  = state;
        tim_psel    = 1'b0;
        tim_penable = 1'b0;
        m0_pready   = 1'b0;
        m0_pslverr  = 1'b0;
        m0_prdata   = '0;
        m1_pready   = 1'b0;
        m1_pslverr  = 1'b0;
        m1_prdata   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                tim_psel   = 1'b1;
                state_next = ACCESS;
            end
            ACCESS: begin
                tim_psel    = 1'b1;
                tim_penable = 1'b1;
                if (complete) begin
                    state_next = IDLE;
                    if (!grant && m0_psel) begin
                        m0_pready  = 1'b1;
                        m0_pslverr = rsp_err;
                        m0_prdata  = rsp_data;
                    end
                    if (grant && m1_psel) begin
                        m1_pready  = 1'b1;
                        m1_pslverr = rsp_err;
                        m1_prdata  = rsp_data;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command fields are captured only at grant time, so they stay stable
    // for the whole SETUP/ACCESS sequence whatever the requesters do.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            tim_pwrite <= 1'b0;
            tim_paddr  <= '0;
            tim_pwdata <= '0;
            tim_pstrb  <= '0;
        end else begin
            if ((state == IDLE) && any_req) begin
                grant      <= pick;
                tim_pwrite <= pick ? m1_pwrite : m0_pwrite;
                tim_paddr  <= pick ? m1_paddr  : m0_paddr;
                tim_pwdata <= pick ? m1_pwdata : m0_pwdata;
                if (pick ? m1_pwrite : m0_pwrite) begin
                    tim_pstrb <= pick ? m1_pstrb : m0_pstrb;
                end else begin
                    tim_pstrb <= '0;
                end
            end
            if (complete) begin
                last_grant <= grant;
            end
        end
    end

endmodule
